mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single 16-bit-word, byte-addressed memory between the control unit (port 0) and a secondary requester such as a loader, debug or DMA port (port 1).
- Sequences each access as a word read, plus a read-modify-write for byte stores, so requesters never perform byte merging themselves.
- Sits between the requesters and the memory's mem_addr / mem_in / mem_out / mem_we pins.

Parameters:
- ADDR_W, 8: byte-address width; word select is addr[ADDR_W-1:1], bit 0 is byte lane.
- WORD_W, 16: memory word width; fixed at 2 bytes.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- p0_req  in  1  port 0 access request, held until p0_ack
- p0_we  in  1  port 0 byte write (1) / word read (0)
- p0_addr  in  ADDR_W  port 0 byte address
- p0_wdata  in  8  port 0 store byte
- p0_ack  out  1  port 0 one-cycle completion pulse
- p0_rdata  out  WORD_W  port 0 read word, the full word containing p0_addr
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: same as port 0, for port 1
- mem_addr  out  ADDR_W  memory byte address, bit 0 always 0
- mem_in  out  WORD_W  memory write word
- mem_we  out  1  memory write enable
- mem_out  in  WORD_W  memory read word; combinational from mem_addr, same cycle
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate):
  - state=IDLE, last_grant=1 (port 0 wins the first tie).
  - p0_ack=p1_ack=0, p0_rdata=p1_rdata=0, mem_we=0, mem_addr=0, mem_in=0, busy=0.
- FSM states: IDLE, RD, WR, ACK.
- IDLE:
  - Neither req high: stay in IDLE.
  - Exactly one req high: grant that port.
  - Both high: grant the port != last_grant.
  - On grant, latch owner, we, word address and wdata; last_grant<=owner; next state RD.
- RD:
  - mem_addr = {latched word addr, 1'b0}; mem_we=0.
  - At the edge, mem_out is captured into the working word.
  - Next state: WR if we=1, else ACK.
- WR:
  - mem_we=1 for exactly this cycle.
  - mem_in = captured word with lane replaced: addr[0]=0 replaces [7:0], addr[0]=1 replaces [15:8].
  - Next state: ACK.
- ACK:
  - Owner's ack=1 for exactly one cycle.
  - Owner's rdata updates to the captured word (pre-write contents for stores). It holds until that port's next ACK.
  - Next state is always IDLE.
  - The IDLE turnaround cycle is mandatory; it gives the other port a chance at arbitration.
- Latency from the IDLE sampling cycle:
  - Read: ack 2 cycles later.
  - Write: ack 3 cycles later.
  - A continuously requesting port gets at most one access per 3 (read) or 4 (write) cycles.
- Handshake:
  - Requester holds req/we/addr/wdata stable until its ack.
  - Input changes after the grant are ignored (already latched).
  - If req drops mid-transaction, the transaction still completes and is acked.
  - If req is still high in the ACK cycle, it is treated as a new request at the following IDLE.
- Non-owner port: ack=0 and rdata unchanged throughout.
- mem_we is asserted only in WR, never in any other state and never during reset.
- Reset mid-transaction: abandon immediately. A store reset before WR leaves memory untouched; no ack is issued.

Test Plan:
- Reset values: assert rst mid-simulation → all outputs 0 and busy=0 in the same cycle without a clock edge. The first tie after release goes to port 0.
- Port 0 read, memory word at 0x10 = 0xBEEF: p0_req=1, p0_addr=0x11 in IDLE cycle 0 → mem_addr=0x10 in cycle 1, p0_ack=1 and p0_rdata=0xBEEF in cycle 2, mem_we never high.
- Port 1 byte store, word 0x20 = 0x1234, p1_addr=0x21, p1_wdata=0x5A → cycle 2 shows mem_we=1, mem_addr=0x20, mem_in=0x5A34; p1_ack in cycle 3; a later read returns 0x5A34. The same store at 0x20 gives 0x125A.
- Contention: both ports hold req from reset release → grant order port0, port1, port0, port1, with one IDLE cycle between each ACK and the next RD.
- Abort: rst pulsed during the RD cycle of a port 0 store → mem_we stays 0, memory unchanged, no p0_ack, state IDLE.
- Early drop: port 1 read with p1_req dropped in the RD cycle → p1_ack still pulses in the ACK cycle with the correct word; no second access follows.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the two-port memory arbiter.
// The arbiter connects through the slave modport; requesters and the memory model use master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 16
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [7:0]        p0_wdata;
  logic              p0_ack;
  logic [WORD_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [7:0]        p1_wdata;
  logic              p1_ack;
  logic [WORD_W-1:0] p1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_in;
  logic              mem_we;
  logic [WORD_W-1:0] mem_out;
  logic              busy;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_out,
    output p0_ack, p0_rdata, p1_ack, p1_rdata,
    output mem_addr, mem_in, mem_we, busy
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_out,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata,
    input  mem_addr, mem_in, mem_we, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter for a 16-bit-word, byte-addressed memory: alternating grants on
// contention, word reads, and read-modify-write byte stores done on the requester's behalf.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

  state_t            state, state_nxt;
  logic              owner, last_grant, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic [WORD_W-1:0] word;

  logic              grant, grant_sel, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_wdata;

  function automatic logic [WORD_W-1:0] merge_lane(input logic [WORD_W-1:0] w,
                                                   input logic lane,
                                                   input logic [7:0] b);
    merge_lane = lane ? {b, w[7:0]} : {w[WORD_W-1:8], b};
  endfunction

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_sel = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the port that did not win last time is served.
        if (bus.p0_req && bus.p1_req) begin
          grant     = 1'b1;
          grant_sel = ~last_grant;
        end else if (bus.p0_req) begin
          grant     = 1'b1;
          grant_sel = 1'b0;
        end else if (bus.p1_req) begin
          grant     = 1'b1;
          grant_sel = 1'b1;
        end
        if (grant) state_nxt = RD;
      end
      RD:      state_nxt = we_q ? WR : ACK;
      WR:      state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    sel_we    = grant_sel ? bus.p1_we    : bus.p0_we;
    sel_addr  = grant_sel ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = grant_sel ? bus.p1_wdata : bus.p0_wdata;
  end

  always_comb begin
    bus.mem_addr = '0;
    bus.mem_in   = '0;
    bus.mem_we   = 1'b0;
    if (state == RD || state == WR) bus.mem_addr = {addr_q[ADDR_W-1:1], 1'b0};
    if (state == WR) begin
      bus.mem_we = 1'b1;
      bus.mem_in = merge_lane(word, addr_q[0], wdata_q);
    end
    bus.p0_ack = (state == ACK) && !owner;
    bus.p1_ack = (state == ACK) &&  owner;
    bus.busy   = (state != IDLE);
  end

  // Control state and the returned read words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      we_q         <= 1'b0;
      bus.p0_rdata <= '0;
      bus.p1_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner      <= grant_sel;
        last_grant <= grant_sel;
        we_q       <= sel_we;
      end
      // rdata lands on the edge into ACK; stores report the pre-write word.
      if (state == RD && !we_q) begin
        if (owner) bus.p1_rdata <= bus.mem_out;
        else       bus.p0_rdata <= bus.mem_out;
      end
      if (state == WR) begin
        if (owner) bus.p1_rdata <= word;
        else       bus.p0_rdata <= word;
      end
    end
  end

  // Request latch and working word.
  always_ff @(posedge clk) begin
    if (grant) begin
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end
    if (state == RD) word <= bus.mem_out;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, reads, byte stores, contention, abort and early drop
// against a behavioural 128-word memory.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(8), .WORD_W(16)) bus ();

  mem_arbiter #(.ADDR_W(8), .WORD_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem [0:127];
  logic        load_en = 1'b0;
  logic [6:0]  load_idx = '0;
  logic [15:0] load_val = '0;

  assign bus.mem_out = mem[bus.mem_addr[7:1]];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[7:1]] <= bus.mem_in;
    else if (load_en) mem[load_idx] <= load_val;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [6:0] idx, input logic [15:0] val);
    load_en  = 1'b1;
    load_idx = idx;
    load_val = val;
    step();
    load_en  = 1'b0;
  endtask

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [7:0] addr, input logic [7:0] wd);
    if (port) begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wd;
    end else begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wd;
    end
  endtask

  task automatic access(input bit port, input bit we, input logic [7:0] addr,
                        input logic [7:0] wd, output logic [15:0] rd, output bit ok);
    ok = 1'b0;
    rd = 'x;
    drive(port, 1'b1, we, addr, wd);
    for (int i = 0; i < 12; i++) begin
      step();
      if ((port ? bus.p1_ack : bus.p0_ack) === 1'b1) begin
        rd = port ? bus.p1_rdata : bus.p0_rdata;
        ok = 1'b1;
        break;
      end
    end
    drive(port, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.p0_ack, bus.p1_ack, bus.mem_we, bus.busy} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl: got %b, want 0000", {bus.p0_ack, bus.p1_ack, bus.mem_we, bus.busy});
    end
    n_cmp++;
    if ({bus.p0_rdata, bus.p1_rdata} !== 32'h0) begin
      n_err++; $display("FAIL reset_rdata: got %h, want 00000000", {bus.p0_rdata, bus.p1_rdata});
    end
    n_cmp++;
    if ({bus.mem_addr, bus.mem_in} !== 24'h0) begin
      n_err++; $display("FAIL reset_mem: got %h, want 000000", {bus.mem_addr, bus.mem_in});
    end
  endtask

  task automatic test_read();
    poke(7'h08, 16'hBEEF);
    drive(0, 1'b1, 1'b0, 8'h11, 8'h00);
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rd_idle_busy: got %b, want 0", bus.busy); end
    step();
    n_cmp++;
    if ({bus.mem_addr, bus.mem_we, bus.p0_ack} !== {8'h10, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL rd_cycle1: got %h/%b/%b, want 10/0/0", bus.mem_addr, bus.mem_we, bus.p0_ack);
    end
    step();
    n_cmp++;
    if ({bus.p0_ack, bus.p1_ack, bus.mem_we} !== 3'b100) begin
      n_err++; $display("FAIL rd_ack: got %b, want 100", {bus.p0_ack, bus.p1_ack, bus.mem_we});
    end
    n_cmp++;
    if (bus.p0_rdata !== 16'hBEEF) begin n_err++; $display("FAIL rd_data: got %h, want beef", bus.p0_rdata); end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    n_cmp++;
    if ({bus.p0_ack, bus.busy, bus.p0_rdata} !== {2'b00, 16'hBEEF}) begin
      n_err++; $display("FAIL rd_after: got %b/%b/%h, want 0/0/beef", bus.p0_ack, bus.busy, bus.p0_rdata);
    end
  endtask

  task automatic test_store();
    logic [15:0] rd;
    bit ok;
    poke(7'h10, 16'h1234);
    drive(1, 1'b1, 1'b1, 8'h21, 8'h5A);
    step();
    n_cmp++;
    if ({bus.mem_addr, bus.mem_we} !== {8'h20, 1'b0}) begin
      n_err++; $display("FAIL st_rd: got %h/%b, want 20/0", bus.mem_addr, bus.mem_we);
    end
    step();
    n_cmp++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_in, bus.p1_ack} !== {1'b1, 8'h20, 16'h5A34, 1'b0}) begin
      n_err++; $display("FAIL st_wr: got %b/%h/%h/%b, want 1/20/5a34/0", bus.mem_we, bus.mem_addr, bus.mem_in, bus.p1_ack);
    end
    step();
    n_cmp++;
    if ({bus.p1_ack, bus.p0_ack, bus.mem_we, bus.p1_rdata} !== {3'b100, 16'h1234}) begin
      n_err++; $display("FAIL st_ack: got %b%b%b/%h, want 100/1234", bus.p1_ack, bus.p0_ack, bus.mem_we, bus.p1_rdata);
    end
    n_cmp++;
    if (mem[7'h10] !== 16'h5A34) begin n_err++; $display("FAIL st_hi_mem: got %h, want 5a34", mem[7'h10]); end
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    access(1, 1'b0, 8'h21, 8'h00, rd, ok);
    n_cmp++;
    if (!ok || rd !== 16'h5A34) begin n_err++; $display("FAIL st_readback: got %h ok=%0d, want 5a34", rd, ok); end
    poke(7'h10, 16'h1234);
    access(1, 1'b1, 8'h20, 8'h5A, rd, ok);
    n_cmp++;
    if (!ok || rd !== 16'h1234) begin n_err++; $display("FAIL st_lo_ack: got %h ok=%0d, want 1234", rd, ok); end
    n_cmp++;
    if (mem[7'h10] !== 16'h125A) begin n_err++; $display("FAIL st_lo_mem: got %h, want 125a", mem[7'h10]); end
  endtask

  task automatic test_reset_mid();
    poke(7'h18, 16'h7777);
    drive(0, 1'b1, 1'b1, 8'h31, 8'hAA);
    step();
    step();
    n_cmp++;
    if (bus.mem_we !== 1'b1) begin n_err++; $display("FAIL rm_in_wr: got %b, want 1", bus.mem_we); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.p0_ack, bus.p1_ack, bus.mem_we, bus.busy, bus.mem_addr, bus.mem_in} !== 28'h0) begin
      n_err++; $display("FAIL rm_outputs: got %h, want 0", {bus.p0_ack, bus.p1_ack, bus.mem_we, bus.busy, bus.mem_addr, bus.mem_in});
    end
    n_cmp++;
    if ({bus.p0_rdata, bus.p1_rdata} !== 32'h0) begin
      n_err++; $display("FAIL rm_rdata: got %h, want 0", {bus.p0_rdata, bus.p1_rdata});
    end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    rst = 1'b0;
    step();
    n_cmp++;
    if (mem[7'h18] !== 16'h7777) begin n_err++; $display("FAIL rm_mem: got %h, want 7777", mem[7'h18]); end
  endtask

  task automatic test_abort();
    int we_seen = 0;
    int ack_seen = 0;
    drive(0, 1'b1, 1'b1, 8'h31, 8'hAA);
    step();
    n_cmp++;
    if ({bus.busy, bus.mem_addr, bus.mem_we} !== {1'b1, 8'h30, 1'b0}) begin
      n_err++; $display("FAIL ab_rd: got %b/%h/%b, want 1/30/0", bus.busy, bus.mem_addr, bus.mem_we);
    end
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.mem_we === 1'b1) we_seen++;
      if (bus.p0_ack === 1'b1) ack_seen++;
      step();
    end
    n_cmp++;
    if ({we_seen, ack_seen} !== 64'h0) begin
      n_err++; $display("FAIL ab_activity: got we=%0d ack=%0d, want 0/0", we_seen, ack_seen);
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ab_idle: got %b, want 0", bus.busy); end
    n_cmp++;
    if (mem[7'h18] !== 16'h7777) begin n_err++; $display("FAIL ab_mem: got %h, want 7777", mem[7'h18]); end
  endtask

  task automatic test_contention();
    logic [2:0] want;
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h20, 8'h00);
    step();
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k % 3 == 2) want = ((k / 3) % 2 == 0) ? 3'b101 : 3'b011;
      else if (k % 3 == 0) want = 3'b000;
      else want = 3'b001;
      n_cmp++;
      if ({bus.p0_ack, bus.p1_ack, bus.busy} !== want) begin
        n_err++; $display("FAIL cont_cyc%0d: got ack0/ack1/busy=%b, want %b", k, {bus.p0_ack, bus.p1_ack, bus.busy}, want);
      end
    end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    n_cmp++;
    if ({bus.p0_rdata, bus.p1_rdata} !== {16'hBEEF, 16'h125A}) begin
      n_err++; $display("FAIL cont_rdata: got %h, want beef125a", {bus.p0_rdata, bus.p1_rdata});
    end
    step();
  endtask

  task automatic test_early_drop();
    poke(7'h20, 16'hCAFE);
    drive(1, 1'b1, 1'b0, 8'h40, 8'h00);
    step();
    n_cmp++;
    if ({bus.busy, bus.mem_addr} !== {1'b1, 8'h40}) begin
      n_err++; $display("FAIL ed_rd: got %b/%h, want 1/40", bus.busy, bus.mem_addr);
    end
    drive(1, 1'b0, 1'b0, 8'h40, 8'h00);
    step();
    n_cmp++;
    if ({bus.p1_ack, bus.p1_rdata} !== {1'b1, 16'hCAFE}) begin
      n_err++; $display("FAIL ed_ack: got %b/%h, want 1/cafe", bus.p1_ack, bus.p1_rdata);
    end
    step();
    n_cmp++;
    if ({bus.busy, bus.p1_ack} !== 2'b00) begin n_err++; $display("FAIL ed_idle1: got %b, want 00", {bus.busy, bus.p1_ack}); end
    step();
    n_cmp++;
    if ({bus.busy, bus.p1_ack} !== 2'b00) begin n_err++; $display("FAIL ed_idle2: got %b, want 00", {bus.busy, bus.p1_ack}); end
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    step();
    step();
    test_reset();
    rst = 1'b0;
    step();
    test_read();
    test_store();
    test_reset_mid();
    test_abort();
    test_contention();
    test_early_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
